// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared types and constants for the MIPS CPU front end.
//   fetch_state_t        - pc_fetch controller states
//   DEFAULT_RESET_VECTOR - first PC fetched after reset
//   DEFAULT_HALT_ADDR    - PC at which execution ends
//   INSTR_BYTES          - sequential PC increment
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES          = 32'd4;

endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: instruction-memory read bus (Avalon-MM style, read only).
//   imem_address     - byte address, driven by the fetch unit
//   imem_read        - read request, driven by the fetch unit
//   imem_waitrequest - memory stall, request must stay unchanged while high
//   imem_readdata    - instruction word, valid when read=1 and waitrequest=0
// Modports: master (fetch unit), slave (memory).
interface pc_fetch_if;

    logic [31:0] imem_address;
    logic        imem_read;
    logic        imem_waitrequest;
    logic [31:0] imem_readdata;

    modport master (
        output imem_address,
        output imem_read,
        input  imem_waitrequest,
        input  imem_readdata
    );

    modport slave (
        input  imem_address,
        input  imem_read,
        output imem_waitrequest,
        output imem_readdata
    );

endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: instruction fetch unit with one architectural branch delay slot.
// Fetches one word per instruction, holds it for the core until it is
// retired with 'advance', then fetches the next PC (sequential, delay slot
// or pending branch target). Execution stops when the next PC equals
// HALT_ADDR.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   imem        - instruction memory bus (pc_fetch_if.master)
//   pcnext      - next PC from next-PC logic, sampled on advance
//   redirect    - pcnext is a taken branch/jump target
//   advance     - core retires the instruction in instr
//   pc, instr   - registered instruction and its address
//   instr_valid - pc/instr valid for the core
//   active      - low once halted
//   align_fault - (FETCH_ALIGN_CHECK_EN only) sticky misaligned-target flag
// Build option: define FETCH_ALIGN_CHECK_EN to halt on misaligned targets;
// otherwise imem_address bits [1:0] are forced to zero.
module pc_fetch
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    pc_fetch_if.master  imem,
    input  logic [31:0] pcnext,
    input  logic        redirect,
    input  logic        advance,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        active
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        align_fault
`endif
);

    fetch_state_t state_q, state_d;

    logic [31:0] fetch_pc_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pend_q;        // branch target waiting behind its delay slot
    logic        pend_valid_q;  // instruction in HOLD is a delay slot

    logic [31:0] next_fetch_pc;
    logic        misaligned;
    logic        stop_fetch;

    // Target of the fetch that follows the retiring instruction. A delay
    // slot always resolves to the pending target, so redirect is ignored.
    always_comb begin
        next_fetch_pc = pcnext;
        if (pend_valid_q) begin
            next_fetch_pc = pend_q;
        end else if (redirect) begin
            next_fetch_pc = pc_q + INSTR_BYTES;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (next_fetch_pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign stop_fetch = (next_fetch_pc == HALT_ADDR) || misaligned;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:  if (!imem.imem_waitrequest) state_d = HOLD;
            HOLD:   if (advance) state_d = stop_fetch ? HALTED : FETCH;
            HALTED: state_d = HALTED;
            default: state_d = FETCH;
        endcase
    end

    // Outputs. The read request is gated by rst_n so a request in flight
    // is dropped during the reset cycle rather than one cycle later.
    always_comb begin
        imem.imem_read = rst_n && (state_q == FETCH);
`ifdef FETCH_ALIGN_CHECK_EN
        imem.imem_address = fetch_pc_q;
`else
        imem.imem_address = {fetch_pc_q[31:2], 2'b00};
`endif
        instr_valid = (state_q == HOLD);
        active      = (state_q != HALTED);
        pc          = pc_q;
        instr       = instr_q;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q   <= RESET_VECTOR;
            pc_q         <= RESET_VECTOR;
            instr_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            align_fault  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (!imem.imem_waitrequest) begin
                        instr_q <= imem.imem_readdata;
                        pc_q    <= fetch_pc_q;
                    end
                end
                HOLD: begin
                    if (advance) begin
                        fetch_pc_q <= next_fetch_pc;
                        if (pend_valid_q) begin
                            pend_valid_q <= 1'b0;
                        end else if (redirect) begin
                            pend_q       <= pcnext;
                            pend_valid_q <= 1'b1;
                        end
`ifdef FETCH_ALIGN_CHECK_EN
                        if (misaligned) align_fault <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: self-checking bench for pc_fetch. Directed scenarios for
// reset, stalls, delay-slot redirect, halt, wrap, reset mid-request and
// alignment, then a randomized run against a program-order PC model.
module tb_pc_fetch;
    import mips_cpu_pkg::*;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pcnext = '0;
    logic        redirect = 1'b0;
    logic        advance = 1'b0;
    logic [31:0] pc, instr;
    logic        instr_valid, active;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        align_fault;
`endif

    int checks = 0;
    int errors = 0;

    pc_fetch_if bus ();

    pc_fetch #(
        .RESET_VECTOR(RV),
        .HALT_ADDR   (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem       (bus.master),
        .pcnext     (pcnext),
        .redirect   (redirect),
        .advance    (advance),
        .pc         (pc),
        .instr      (instr),
        .instr_valid(instr_valid),
        .active     (active)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .align_fault(align_fault)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        advance = 1'b0;
        redirect = 1'b0;
        bus.imem_waitrequest = 1'b0;
        tick();
        tick();
        chk("rst/read", {31'd0, bus.imem_read}, 32'd0);
        chk("rst/pc", pc, RV);
        chk("rst/instr", instr, 32'd0);
        chk("rst/valid", {31'd0, instr_valid}, 32'd0);
        chk("rst/active", {31'd0, active}, 32'd1);
        rst_n = 1'b1;
    endtask

    // One instruction fetch at 'addr', stalled for 'stalls' cycles. Advance
    // is pulsed with junk during the stall to show it is ignored there.
    task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input int unsigned stalls, input bit check_pc);
        bus.imem_readdata = data;
        bus.imem_waitrequest = (stalls != 0);
        #1;
        chk({tag, "/read"}, {31'd0, bus.imem_read}, 32'd1);
        chk({tag, "/addr"}, bus.imem_address, addr);
        for (int unsigned i = 0; i < stalls; i++) begin
            advance = 1'b1;
            redirect = 1'b1;
            pcnext = 32'hDEAD_BEE0;
            tick();
            chk({tag, "/stall_read"}, {31'd0, bus.imem_read}, 32'd1);
            chk({tag, "/stall_addr"}, bus.imem_address, addr);
            chk({tag, "/stall_valid"}, {31'd0, instr_valid}, 32'd0);
        end
        advance = 1'b0;
        redirect = 1'b0;
        bus.imem_waitrequest = 1'b0;
        tick();
        chk({tag, "/valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "/instr"}, instr, data);
        chk({tag, "/read_off"}, {31'd0, bus.imem_read}, 32'd0);
        if (check_pc) chk({tag, "/pc"}, pc, addr);
    endtask

    // Hold the instruction for 'hold' cycles, then retire it.
    task automatic do_retire(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr,
                             input int unsigned hold, input logic [31:0] pn, input logic redir,
                             input bit exp_halt);
        for (int unsigned i = 0; i < hold; i++) begin
            bus.imem_waitrequest = 1'($urandom);
            bus.imem_readdata = $urandom;
            tick();
            chk({tag, "/hold_pc"}, pc, exp_pc);
            chk({tag, "/hold_instr"}, instr, exp_instr);
            chk({tag, "/hold_valid"}, {31'd0, instr_valid}, 32'd1);
        end
        bus.imem_waitrequest = 1'b0;
        advance = 1'b1;
        redirect = redir;
        pcnext = pn;
        tick();
        advance = 1'b0;
        redirect = 1'b0;
        chk({tag, "/ret_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "/ret_active"}, {31'd0, active}, exp_halt ? 32'd0 : 32'd1);
        chk({tag, "/ret_read"}, {31'd0, bus.imem_read}, exp_halt ? 32'd0 : 32'd1);
    endtask

    task automatic check_halted(input string tag, input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) begin
            advance = 1'($urandom);
            redirect = 1'($urandom);
            pcnext = $urandom;
            bus.imem_waitrequest = 1'($urandom);
            tick();
            chk({tag, "/active"}, {31'd0, active}, 32'd0);
            chk({tag, "/read"}, {31'd0, bus.imem_read}, 32'd0);
            chk({tag, "/valid"}, {31'd0, instr_valid}, 32'd0);
        end
        advance = 1'b0;
        redirect = 1'b0;
    endtask

    initial begin
        logic [31:0] cur_pc, cur_instr, nxt, pn, pend, data, r;
        logic        pend_v, redir;

        bus.imem_waitrequest = 1'b0;
        bus.imem_readdata = '0;

        // Reset and first fetch, then a 3-cycle stall on the second
        apply_reset();
        do_fetch("first", RV, 32'h2402_0005, 0, 1'b1);
        do_retire("seq0", RV, 32'h2402_0005, 1, RV + 32'd4, 1'b0, 1'b0);
        do_fetch("stall3", RV + 32'd4, 32'hA000_0004, 3, 1'b1);
        do_retire("seq1", RV + 32'd4, 32'hA000_0004, 0, RV + 32'd8, 1'b0, 1'b0);
        do_fetch("seq2", RV + 32'd8, 32'hA000_0008, 0, 1'b1);
        do_retire("seq2", RV + 32'd8, 32'hA000_0008, 0, RV + 32'hC, 1'b0, 1'b0);
        do_fetch("seq3", RV + 32'hC, 32'hA000_000C, 1, 1'b1);
        do_retire("seq3", RV + 32'hC, 32'hA000_000C, 0, 32'hBFC0_0010, 1'b0, 1'b0);
        do_fetch("seq4", 32'hBFC0_0010, 32'hA000_0010, 0, 1'b1);

        // Branch at BFC00010: delay slot first, then target; a redirect on
        // the delay slot itself is ignored
        do_retire("br", 32'hBFC0_0010, 32'hA000_0010, 0, 32'hBFC0_0100, 1'b1, 1'b0);
        do_fetch("dslot", 32'hBFC0_0014, 32'hA000_0014, 0, 1'b1);
        do_retire("dslot", 32'hBFC0_0014, 32'hA000_0014, 2, 32'h1234_5670, 1'b1, 1'b0);
        do_fetch("target", 32'hBFC0_0100, 32'hA000_0100, 0, 1'b1);

`ifdef FETCH_ALIGN_CHECK_EN
        chk("align/pre", {31'd0, align_fault}, 32'd0);
        do_retire("align", 32'hBFC0_0100, 32'hA000_0100, 0, 32'hBFC0_0102, 1'b0, 1'b1);
        chk("align/fault", {31'd0, align_fault}, 32'd1);
        check_halted("align_halt", 3);
        chk("align/sticky", {31'd0, align_fault}, 32'd1);
        apply_reset();
        chk("align/cleared", {31'd0, align_fault}, 32'd0);
`else
        do_retire("unalign", 32'hBFC0_0100, 32'hA000_0100, 0, 32'hBFC0_0102, 1'b0, 1'b0);
        do_fetch("unalign", 32'hBFC0_0100, 32'hA000_0102, 0, 1'b0);
        apply_reset();
`endif

        // pc+4 wraps from FFFFFFFC to 0 == HALT_ADDR: delay slot halts
        do_fetch("wrap0", RV, 32'h0000_0001, 0, 1'b1);
        do_retire("wrap0", RV, 32'h0000_0001, 0, 32'hFFFF_FFFC, 1'b0, 1'b0);
        do_fetch("wrap1", 32'hFFFF_FFFC, 32'h0000_0002, 0, 1'b1);
        do_retire("wrap1", 32'hFFFF_FFFC, 32'h0000_0002, 0, 32'h0000_4000, 1'b1, 1'b1);
        check_halted("wrap_halt", 2);

        // Jump to HALT_ADDR: delay slot still fetched, then halt
        apply_reset();
        do_fetch("jh0", RV, 32'h0800_0000, 0, 1'b1);
        do_retire("jh0", RV, 32'h0800_0000, 0, 32'h0000_0000, 1'b1, 1'b0);
        do_fetch("jh_ds", RV + 32'd4, 32'h0000_0000, 2, 1'b1);
        do_retire("jh_ds", RV + 32'd4, 32'h0000_0000, 0, 32'h0000_1000, 1'b0, 1'b1);
        check_halted("jh_halt", 4);

        // Reset during a stalled read: stale data must not be captured
        apply_reset();
        do_fetch("mr0", RV, 32'h3333_3333, 0, 1'b1);
        do_retire("mr0", RV, 32'h3333_3333, 0, 32'hBFC0_0200, 1'b0, 1'b0);
        bus.imem_waitrequest = 1'b1;
        bus.imem_readdata = 32'h1111_1111;
        tick();
        tick();
        chk("mr/stalled_addr", bus.imem_address, 32'hBFC0_0200);
        rst_n = 1'b0;
        #1;
        chk("mr/read_in_rst", {31'd0, bus.imem_read}, 32'd0);
        bus.imem_waitrequest = 1'b0;
        tick();
        chk("mr/instr", instr, 32'd0);
        chk("mr/pc", pc, RV);
        chk("mr/valid", {31'd0, instr_valid}, 32'd0);
        rst_n = 1'b1;
        do_fetch("mr_restart", RV, 32'h2222_2222, 0, 1'b1);

        // Randomized program: model tracks the architectural fetch order
        cur_pc = RV;
        cur_instr = 32'h2222_2222;
        pend_v = 1'b0;
        pend = '0;
        for (int i = 0; i < 200; i++) begin
            redir = ($urandom_range(3) == 0);
            r = $urandom;
            pn = {r[31:2], 2'b00};
            if (pn == 32'h0 || pn == 32'hFFFF_FFFC) pn = 32'h0000_0008;
            if (pend_v) begin
                nxt = pend;
                pend_v = 1'b0;
            end else if (redir) begin
                pend = pn;
                pend_v = 1'b1;
                nxt = cur_pc + 32'd4;
            end else begin
                nxt = pn;
            end
            do_retire("rnd", cur_pc, cur_instr, $urandom_range(2), pn, redir, 1'b0);
            data = $urandom;
            do_fetch("rnd", nxt, data, $urandom_range(3), 1'b1);
            cur_pc = nxt;
            cur_instr = data;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
